// File: rtl/rs232_pkg.sv
// Shared RS232 receive types and constants.
// Used by a_demux_serial_16v1 and rs232_rx_sync.
package rs232_pkg;

  localparam int RS232_DATA_BITS  = 8;
  localparam int RS232_WORD_BYTES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP,
    S_ERR_WAIT
  } rx_state_e;

  function automatic int cnt_width(input int os);
    return $clog2(os);
  endfunction

endpackage

// File: rtl/rs232_rx_sync.sv
// RX line synchroniser plus idle-line detector
// used to leave the error-wait state.
module rs232_rx_sync
  import rs232_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic rx_i,
  input  logic wait_i,
  output logic rx_s_o,
  output logic idle_o
);

  localparam int CW = cnt_width(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rx_s_o = sync_q[1];

  // Pulses on the OVERSAMPLE-th consecutive high tick
  assign idle_o = wait_i & tick_i & rx_s_o & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!wait_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (!rx_s_o || idle_o) cnt_d = '0;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/a_demux_serial_16v1.sv
// 2-frame 8N1 receiver assembling a 16-bit word, low byte first.
// Define A_DEMUX_GAP_TIMEOUT_EN to abort on a long inter-byte gap.
module a_demux_serial_16v1
  import rs232_pkg::*;
#(
  parameter int OVERSAMPLE       = 16,
  parameter int GAP_TIMEOUT_BITS = 32
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        clk_sample,
  input  logic        rx_i,
  output logic [15:0] r_data_o,
  output logic        r_dv_o,
  output logic        r_frame_err_o,
  output logic        r_busy_o
);

  localparam int CW = cnt_width(OVERSAMPLE);
  localparam int DW = RS232_DATA_BITS;
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BLST = 3'(DW - 1);

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   scnt_q, scnt_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic            idx_q, idx_d;
  logic [DW-1:0]   shf_q, shf_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [8*RS232_WORD_BYTES-1:0] data_q, data_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;
  logic            rx_s;
  logic            line_idle;
  logic            gap_exp;

  rs232_rx_sync #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sync (
    .clk_i  (clk_ref),
    .rst_ni (rst_n),
    .tick_i (clk_sample),
    .rx_i   (rx_i),
    .wait_i (state_q == S_ERR_WAIT),
    .rx_s_o (rx_s),
    .idle_o (line_idle)
  );

`ifdef A_DEMUX_GAP_TIMEOUT_EN
  localparam logic [15:0] GAP_LAST =
    16'(GAP_TIMEOUT_BITS * OVERSAMPLE - 1);

  logic [15:0] gap_q, gap_d;

  assign gap_exp = (state_q == S_GAP) & clk_sample
                 & rx_s & (gap_q == GAP_LAST);

  always_comb begin
    gap_d = gap_q;
    if (state_q != S_GAP || state_d != S_GAP) gap_d = '0;
    else if (clk_sample && gap_q != 16'hFFFF) gap_d = gap_q + 1'b1;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign gap_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    shf_d   = shf_q;
    lo_d    = lo_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    if (clk_sample) begin
      unique case (state_q)
        S_IDLE: if (!rx_s) begin
          state_d = S_START;
          scnt_d  = '0;
          idx_d   = 1'b0;
        end
        S_START: begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == MID) begin
            scnt_d = '0;
            bcnt_d = '0;
            // A glitch that is gone by mid-bit is not a start bit
            if (rx_s) state_d = idx_q ? S_GAP : S_IDLE;
            else      state_d = S_DATA;
          end
        end
        S_DATA: begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == LAST) begin
            shf_d  = {rx_s, shf_q[DW-1:1]};
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == BLST) state_d = S_STOP;
          end
        end
        S_STOP: begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == LAST) begin
            if (!rx_s) begin
              fe_d    = 1'b1;
              state_d = S_ERR_WAIT;
            end else if (!idx_q) begin
              lo_d    = shf_q;
              state_d = S_GAP;
            end else begin
              data_d  = {shf_q, lo_q};
              dv_d    = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (!rx_s) begin
            state_d = S_START;
            scnt_d  = '0;
            idx_d   = 1'b1;
          end else if (gap_exp) begin
            fe_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_ERR_WAIT: if (line_idle) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      idx_q   <= 1'b0;
      shf_q   <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      shf_q   <= shf_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign r_data_o      = data_q;
  assign r_dv_o        = dv_q;
  assign r_frame_err_o = fe_q;
  assign r_busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_a_demux_serial_16v1.sv
// Directed bench for a_demux_serial_16v1 (OVERSAMPLE=16).
// Gap-timeout expectations follow A_DEMUX_GAP_TIMEOUT_EN.
module tb_a_demux_serial_16v1;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_sample = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] r_data_o;
  logic        r_dv_o;
  logic        r_frame_err_o;
  logic        r_busy_o;

  int nvec = 0;
  int nerr = 0;
  int dv_n = 0;
  int fe_n = 0;
  logic busy_at_dv = 1'b1;
  logic [15:0] dvq[$];
  logic [1:0] divc = 2'd0;

  a_demux_serial_16v1 #(
    .OVERSAMPLE(OS),
    .GAP_TIMEOUT_BITS(32)
  ) dut (
    .clk_ref      (clk),
    .rst_n        (rst_n),
    .clk_sample   (clk_sample),
    .rx_i         (rx),
    .r_data_o     (r_data_o),
    .r_dv_o       (r_dv_o),
    .r_frame_err_o(r_frame_err_o),
    .r_busy_o     (r_busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    divc = divc + 2'd1;
    clk_sample = (divc == 2'd0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (r_dv_o) begin
        dv_n++;
        dvq.push_back(r_data_o);
        busy_at_dv = r_busy_o;
      end
      if (r_frame_err_o) fe_n++;
      if (r_dv_o || r_frame_err_o) begin
        nvec++;
        if (r_dv_o && r_frame_err_o) begin
          nerr++;
          $display("FAIL dv_fe_overlap: dv=%b fe=%b, need not both",
                   r_dv_o, r_frame_err_o);
        end
      end
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!clk_sample) @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stopv);
  endtask

  task automatic send_word(input logic [15:0] w, input logic stop2);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], stop2);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(r_data_o), 32'h0);
    chk("rst_dv", 32'(r_dv_o), 32'h0);
    chk("rst_fe", 32'(r_frame_err_o), 32'h0);
    chk("rst_busy", 32'(r_busy_o), 32'h0);
    wait_tick();
    rst_n = 1'b1;
    wait_ticks(OS);
  endtask

  task automatic test_basic();
    int dv0, fe0;
    dv0 = dv_n; fe0 = fe_n;
    send_word(16'hA55A, 1'b1);
    send_bit(1'b1);
    chk("basic_dv_cnt", 32'(dv_n - dv0), 32'd1);
    chk("basic_data", 32'(r_data_o), 32'hA55A);
    chk("basic_busy_at_dv", 32'(busy_at_dv), 32'h0);
    chk("basic_fe_cnt", 32'(fe_n - fe0), 32'd0);
  endtask

  task automatic test_false_start();
    int dv0, fe0;
    dv0 = dv_n; fe0 = fe_n;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(2 * OS);
    chk("fs_dv_cnt", 32'(dv_n - dv0), 32'd0);
    chk("fs_fe_cnt", 32'(fe_n - fe0), 32'd0);
    chk("fs_busy", 32'(r_busy_o), 32'h0);
    send_word(16'h1234, 1'b1);
    send_bit(1'b1);
    chk("fs_next_dv", 32'(dv_n - dv0), 32'd1);
    chk("fs_next_data", 32'(r_data_o), 32'h1234);
  endtask

  task automatic test_frame_err();
    int dv0, fe0;
    dv0 = dv_n; fe0 = fe_n;
    send_word(16'h7733, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("fe_cnt", 32'(fe_n - fe0), 32'd1);
    chk("fe_dv_cnt", 32'(dv_n - dv0), 32'd0);
    chk("fe_data_kept", 32'(r_data_o), 32'h1234);
    chk("fe_busy_after", 32'(r_busy_o), 32'h0);
    send_word(16'hBEEF, 1'b1);
    send_bit(1'b1);
    chk("fe_next_dv", 32'(dv_n - dv0), 32'd1);
    chk("fe_next_data", 32'(r_data_o), 32'hBEEF);
  endtask

  task automatic test_gap();
    int dv0, fe0;
    dv0 = dv_n; fe0 = fe_n;
    send_byte(8'h11, 1'b1);
`ifdef A_DEMUX_GAP_TIMEOUT_EN
    wait_ticks(30 * OS);
    chk("gap_fe_early", 32'(fe_n - fe0), 32'd0);
    chk("gap_busy_early", 32'(r_busy_o), 32'h1);
    wait_ticks(10 * OS);
    chk("gap_fe_timeout", 32'(fe_n - fe0), 32'd1);
    chk("gap_busy_timeout", 32'(r_busy_o), 32'h0);
    chk("gap_dv_cnt", 32'(dv_n - dv0), 32'd0);
`else
    wait_ticks(40 * OS);
    chk("gap_fe_none", 32'(fe_n - fe0), 32'd0);
    chk("gap_busy_hold", 32'(r_busy_o), 32'h1);
    send_byte(8'h22, 1'b1);
    send_bit(1'b1);
    chk("gap_dv_cnt", 32'(dv_n - dv0), 32'd1);
    chk("gap_data", 32'(r_data_o), 32'h2211);
`endif
  endtask

  task automatic test_back_to_back();
    int base;
    logic [15:0] exp [3];
    exp[0] = 16'h0001;
    exp[1] = 16'hFFFF;
    exp[2] = 16'h8000;
    base = dvq.size();
    for (int i = 0; i < 3; i++) send_word(exp[i], 1'b1);
    send_bit(1'b1);
    chk("b2b_count", 32'(dvq.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < dvq.size())
        chk($sformatf("b2b_word%0d", i), 32'(dvq[base + i]),
            32'(exp[i]));
    end
  endtask

  task automatic test_reset_mid();
    int dv0, fe0;
    logic [7:0] b;
    b = 8'hA7;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    chk("mid_busy_pre", 32'(r_busy_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(r_data_o), 32'h0);
    chk("mid_rst_busy", 32'(r_busy_o), 32'h0);
    chk("mid_rst_dv", 32'(r_dv_o), 32'h0);
    chk("mid_rst_fe", 32'(r_frame_err_o), 32'h0);
    rx = 1'b1;
    wait_ticks(4);
    rst_n = 1'b1;
    dv0 = dv_n; fe0 = fe_n;
    wait_ticks(OS);
    send_word(16'hC3A7, 1'b1);
    send_bit(1'b1);
    chk("mid_next_dv", 32'(dv_n - dv0), 32'd1);
    chk("mid_next_fe", 32'(fe_n - fe0), 32'd0);
    chk("mid_next_data", 32'(r_data_o), 32'hC3A7);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
